rr_arb_8: RTL and testbench

Eight-way round-robin arbiter that shares one resource slot among eight requesters. It drives the resource's select lines as a 3-bit index plus enable, the same encoding consumed by the team's 3-to-8 enable decoder, and also presents the decoded one-hot grant. Ownership lasts until the owner signals done, drops its request, or exceeds a programmable hold limit. The block sits between requesting engines and any shared, decoder-selected resource such as a bus, memory bank or peripheral chip select.

---
 rtl/rr_arb_8.sv | 136 +++++++++++++
 tb/tb_rr_arb_8.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_8.sv
// -----------------------------------------------------------------------------
// rr_arb_8 -- eight-way round-robin arbiter with hold limit
//
// Shares one decoder-selected resource among eight requesters. The owner keeps
// the grant until it pulses done, drops its request, or reaches the hold
// limit. Every change of owner passes through one IDLE cycle.
//
// Parameters
//   MAX_HOLD   maximum grant length in cycles, 0..255 (0 = unlimited)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   level-sensitive request vector, bit i = requester i
//   done       owner release strobe, ignored while grant_vld=0
//   grant_idx  registered index of the current owner
//   grant_vld  registered grant enable (decoder enable)
//   grant[7:0] registered one-hot grant, zero while grant_vld=0
//   timeout    one-cycle pulse when the hold limit alone revoked the owner
// -----------------------------------------------------------------------------
module rr_arb_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_vld,
  output logic [7:0] grant,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  localparam bit         LP_LIM_EN = (MAX_HOLD != 0);
  // hold_cnt is 0 in the first owned cycle, so the last allowed cycle sees N-1
  localparam logic [7:0] LP_LIM    = 8'(MAX_HOLD - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_last,  w_last_nxt;
  logic [2:0] r_idx,   w_idx_nxt;
  logic       r_vld,   w_vld_nxt;
  logic [7:0] r_grant, w_grant_nxt;
  logic       r_to,    w_to_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;

  logic       w_found;
  logic [2:0] w_pick;
  logic       w_rel_done, w_rel_drop, w_rel_lim;

  // Rotating priority scan: (last+1) first, wrapping mod 8, last itself last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      if (!w_found && req[r_last + 3'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_last + 3'(k);
      end
    end
  end

  assign w_rel_done = done;
  assign w_rel_drop = ~req[r_idx];
  assign w_rel_lim  = LP_LIM_EN && (r_cnt == LP_LIM);

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = r_vld;
    w_grant_nxt = r_grant;
    w_to_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_vld_nxt   = 1'b0;
        w_grant_nxt = 8'h00;
        if (w_found) begin
          w_idx_nxt   = w_pick;
          w_vld_nxt   = 1'b1;
          w_grant_nxt = 8'h01 << w_pick;
          w_cnt_nxt   = 8'h00;
          w_state_nxt = S_OWN;
        end
      end
      S_OWN: begin
        if (w_rel_done || w_rel_drop || w_rel_lim) begin
          w_vld_nxt   = 1'b0;
          w_grant_nxt = 8'h00;
          w_last_nxt  = r_idx;
          w_state_nxt = S_IDLE;
          // Only flag a timeout when the limit is the sole reason to release.
          w_to_nxt    = w_rel_lim && !w_rel_done && !w_rel_drop;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_vld_nxt   = 1'b0;
        w_grant_nxt = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 3'd7;
      r_idx   <= 3'd0;
      r_vld   <= 1'b0;
      r_grant <= 8'h00;
      r_to    <= 1'b0;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
      r_vld   <= w_vld_nxt;
      r_grant <= w_grant_nxt;
      r_to    <= w_to_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign grant_idx = r_idx;
  assign grant_vld = r_vld;
  assign grant     = r_grant;
  assign timeout   = r_to;

endmodule

// File: tb/tb_rr_arb_8.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_8 -- scoreboard bench for rr_arb_8
//
// The stimulus process drives req/done once per cycle and queues the outputs
// expected after the next rising edge, tagged with the cycle they belong to.
// A monitor on the falling edge pops and compares those entries. Two DUTs
// share all inputs: one with MAX_HOLD=16 and one with MAX_HOLD=0.
// -----------------------------------------------------------------------------
module tb_rr_arb_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;

  logic [2:0] a_idx,   b_idx;
  logic       a_vld,   b_vld;
  logic [7:0] a_grant, b_grant;
  logic       a_to,    b_to;

  rr_arb_8 #(.MAX_HOLD(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant_idx(a_idx), .grant_vld(a_vld), .grant(a_grant), .timeout(a_to)
  );

  rr_arb_8 #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant_idx(b_idx), .grant_vld(b_vld), .grant(b_grant), .timeout(b_to)
  );

  typedef struct {
    int         cyc;
    int         tgt;    // 0 = MAX_HOLD=16 instance, 1 = MAX_HOLD=0 instance
    logic [7:0] grant;
    logic       to;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   mode   = 0;     // 0: check u_dut, 1: both, 2: u_dut0 only
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  task automatic cmp_out(input string nm, input logic vld, input logic to,
                         input logic [7:0] g, input logic [2:0] idx,
                         input logic [7:0] eg, input logic eto);
    logic ev;
    logic [12:0] act, exp;
    ev  = (eg != 8'h00);
    act = {vld, to, g, ev ? idx : 3'd0};
    exp = {ev, eto, eg, ev ? oh2idx(eg) : 3'd0};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got vld=%0b to=%0b grant=%02h idx=%0d, required vld=%0b to=%0b grant=%02h idx=%0d",
               nm, cyc, vld, to, g, idx, ev, eto, eg, oh2idx(eg));
    end
  endtask

  // Monitor: compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.tgt == 0) cmp_out(e.nm, a_vld, a_to, a_grant, a_idx, e.grant, e.to);
      else            cmp_out({e.nm, "/mh0"}, b_vld, b_to, b_grant, b_idx, e.grant, e.to);
    end
  end

  // One cycle of stimulus; expectation applies after the next rising edge.
  task automatic drive(input logic [7:0] r, input logic d,
                       input logic [7:0] eg, input logic et, input string nm);
    exp_t e;
    req     = r;
    done    = d;
    e.cyc   = cyc + 1;
    e.grant = eg;
    e.to    = et;
    e.nm    = nm;
    if (mode != 2) begin e.tgt = 0; sb.push_back(e); end
    if (mode != 0) begin e.tgt = 1; sb.push_back(e); end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req   = 8'hFF;
    done  = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held with all requests active
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_out("reset", a_vld, a_to, a_grant, a_idx, 8'h00, 1'b0);
    cmp_out("reset/mh0", b_vld, b_to, b_grant, b_idx, 8'h00, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Round robin over all eight with wrap back to 0
    for (int i = 0; i <= 8; i++) begin
      drive(8'hFF, 1'b0, 8'h01 << (i % 8), 1'b0, "rr_grant");
      drive(8'hFF, 1'b1, 8'h00, 1'b0, "rr_release");
    end

    // Sparse requesters 7 and 2 (last=0 here)
    drive(8'h84, 1'b0, 8'h04, 1'b0, "sparse_g2");
    drive(8'h84, 1'b1, 8'h00, 1'b0, "sparse_rel");
    drive(8'h84, 1'b0, 8'h80, 1'b0, "sparse_g7");
    drive(8'h84, 1'b1, 8'h00, 1'b0, "sparse_rel");
    drive(8'h84, 1'b0, 8'h04, 1'b0, "sparse_wrap_g2");
    drive(8'h84, 1'b1, 8'h00, 1'b0, "sparse_rel");

    // Request drop by owner 3 after four owned cycles
    drive(8'h28, 1'b0, 8'h08, 1'b0, "drop_g3");
    for (int i = 0; i < 3; i++) drive(8'h28, 1'b0, 8'h08, 1'b0, "drop_hold");
    drive(8'h20, 1'b0, 8'h00, 1'b0, "drop_rel");
    drive(8'h28, 1'b0, 8'h20, 1'b0, "drop_next_g5");
    drive(8'h28, 1'b1, 8'h00, 1'b0, "drop_next_rel");

    // Hold limit 16: exactly 16 granted cycles, timeout, one idle, re-grant
    drive(8'h10, 1'b0, 8'h10, 1'b0, "lim_g4");
    for (int i = 0; i < 15; i++) drive(8'h10, 1'b0, 8'h10, 1'b0, "lim_hold");
    drive(8'h10, 1'b0, 8'h00, 1'b1, "lim_timeout");
    drive(8'h10, 1'b0, 8'h10, 1'b0, "lim_regrant");
    // done coinciding with the limit: normal release
    for (int i = 0; i < 15; i++) drive(8'h10, 1'b0, 8'h10, 1'b0, "lim_hold2");
    drive(8'h10, 1'b1, 8'h00, 1'b0, "lim_done_at16");
    // request drop coinciding with the limit: normal release
    drive(8'h10, 1'b0, 8'h10, 1'b0, "lim_regrant3");
    for (int i = 0; i < 15; i++) drive(8'h10, 1'b0, 8'h10, 1'b0, "lim_hold3");
    drive(8'h00, 1'b0, 8'h00, 1'b0, "lim_drop_at16");

    // Async reset while grant=8'h20, between clock edges
    drive(8'h20, 1'b0, 8'h20, 1'b0, "pre_areset_g5");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    cmp_out("areset_now", a_vld, a_to, a_grant, a_idx, 8'h00, 1'b0);
    cmp_out("areset_now/mh0", b_vld, b_to, b_grant, b_idx, 8'h00, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mode = 1;
    drive(8'hFF, 1'b0, 8'h01, 1'b0, "areset_restart_g0");
    drive(8'hFF, 1'b1, 8'h00, 1'b0, "areset_restart_rel");

    // MAX_HOLD=0: grant held indefinitely
    mode = 2;
    drive(8'h02, 1'b0, 8'h02, 1'b0, "nolim_g1");
    for (int i = 0; i < 20; i++) drive(8'h02, 1'b0, 8'h02, 1'b0, "nolim_hold");
    drive(8'h02, 1'b1, 8'h00, 1'b0, "nolim_rel");

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
